voice_mixer: RTL

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/voice_mixer_pkg.sv | 12 +
 rtl/voice_mixer_sat_shift.sv | 28 ++
 rtl/voice_mixer.sv | 105 ++++++++++
 3 files changed

// File: rtl/voice_mixer_pkg.sv
// Shared synth constants for the voice path: slot count, sample width,
// phase-bank count and the mixer state encoding.
package voice_mixer_pkg;

    localparam int NUM_VOICES  = 10;
    localparam int DATA_W      = 16;
    localparam int PHASE_BANKS = NUM_VOICES;

    localparam logic [0:0] ST_SEEK = 1'b0;
    localparam logic [0:0] ST_MIX  = 1'b1;

endpackage

// File: rtl/voice_mixer_sat_shift.sv
// Arithmetic right shift of the frame sum followed by saturation
// to the signed sample range, with a clip flag.
module sat_shift #(
    parameter int ACC_W  = 21,
    parameter int DATA_W = 16,
    parameter int SHIFT  = 2
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_clip
);

    logic signed [ACC_W-1:0] sh;
    logic                    fits;

    always_comb begin
        sh   = i_acc >>> SHIFT;
        // value fits when every bit above the sample sign bit matches it
        fits = (&sh[ACC_W-1:DATA_W-1]) | ~(|sh[ACC_W-1:DATA_W-1]);
        if (fits) begin
            o_data = sh[DATA_W-1:0];
        end else begin
            o_data = {sh[ACC_W-1], {(DATA_W-1){~sh[ACC_W-1]}}};
        end
        o_clip = ~fits;
    end

endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: accumulates one sample per slot over a
// frame, scales and saturates the sum, and hands it off via valid/ready.
module voice_mixer #(
    parameter int NUM_VOICES = voice_mixer_pkg::NUM_VOICES,
    parameter int DATA_W     = voice_mixer_pkg::DATA_W,
    parameter int SHIFT      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_valid,
    input  logic              i_sync,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sat,
    output logic              o_drop
);

    import voice_mixer_pkg::*;

    localparam int ACC_W  = DATA_W + $clog2(NUM_VOICES) + 1;
    localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NUM_VOICES - 1);

    logic [0:0]              state_q, state_d;
    logic [SLOT_W-1:0]       slot_q, slot_d, cur_slot;
    logic signed [ACC_W-1:0] acc_q, acc_d, add_val;
    logic [DATA_W-1:0]       sample_q, sample_d, sat_data;
    logic                    valid_q, valid_d;
    logic                    sat_q, sat_d;
    logic                    drop_q, drop_d;
    logic                    clip, active, frame_done;

    sat_shift #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT)
    ) u_sat (
        .i_acc  (acc_d),
        .o_data (sat_data),
        .o_clip (clip)
    );

    always_comb begin
        active   = (state_q == ST_MIX) || i_sync;
        // sync always means slot 0, whether aligning or realigning
        cur_slot = i_sync ? '0 : slot_q;
        add_val  = i_valid ? {{(ACC_W-DATA_W){i_sample[DATA_W-1]}}, i_sample}
                           : '0;
        state_d  = state_q;
        slot_d   = slot_q;
        acc_d    = acc_q;
        if (active) begin
            state_d = ST_MIX;
            acc_d   = (cur_slot == '0) ? add_val : acc_q + add_val;
            slot_d  = (cur_slot == LAST) ? '0 : cur_slot + SLOT_W'(1);
        end
        frame_done = active && (cur_slot == LAST);
    end

    always_comb begin
        sample_d = sample_q;
        valid_d  = valid_q;
        sat_d    = 1'b0;
        drop_d   = 1'b0;
        if (frame_done) begin
            if (!valid_q || i_ready) begin
                sample_d = sat_data;
                valid_d  = 1'b1;
                sat_d    = clip;
            end else begin
                drop_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SEEK;
            slot_q   <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            acc_q    <= acc_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            sat_q    <= sat_d;
            drop_q   <= drop_d;
        end
    end

    assign o_sample = sample_q;
    assign o_valid  = valid_q;
    assign o_sat    = sat_q;
    assign o_drop   = drop_q;

endmodule
